// File: rtl/board_hit_decode_pkg.sv
// Shared board constants and helpers: coordinate, button-pitch and index widths
// used by the minesweeper board renderer and the pointer hit decoder.
package board_hit_decode_pkg;

  localparam int MAX_BOARD_DIM = 16;
  localparam int IDX_W         = $clog2(MAX_BOARD_DIM);
  localparam int COORD_W       = 11;
  localparam int SIZE_W        = 7;
  localparam int DIM_W         = 5;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [SIZE_W-1:0]  size_t;
  typedef logic [DIM_W-1:0]   dim_t;
  typedef logic [IDX_W-1:0]   idx_t;

  // A click left of/above the first button, or on a degenerate board, can never hit.
  function automatic logic origin_miss(input coord_t mouse_x, input coord_t mouse_y,
                                       input coord_t board_x, input coord_t board_y,
                                       input size_t size, input dim_t cols,
                                       input dim_t rows);
    return (mouse_x <= board_x) || (mouse_y < board_y) ||
           (size == '0) || (cols == '0) || (rows == '0);
  endfunction

endpackage

// File: rtl/board_hit_decode.sv
// Turns a mouse click into a board (col,row) hit or a miss by repeated
// subtraction of the button pitch, one step per clock.
module board_hit_decode
  import board_hit_decode_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] mouse_xpos,
  input  logic [COORD_W-1:0] mouse_ypos,
  input  logic               click_left,
  input  logic               click_right,
  input  logic [COORD_W-1:0] board_xpos,
  input  logic [COORD_W-1:0] board_ypos,
  input  logic [SIZE_W-1:0]  button_size,
  input  logic [DIM_W-1:0]   board_cols,
  input  logic [DIM_W-1:0]   board_rows,
  output logic               busy,
  output logic               hit_valid,
  output logic               miss_valid,
  output logic [IDX_W-1:0]   hit_col,
  output logic [IDX_W-1:0]   hit_row,
  output logic               hit_flag
);

  typedef enum logic [2:0] {IDLE, DIV_X, DIV_Y, DONE, MISS} state_t;

  state_t r_state, w_state_next;

  coord_t r_off_x, r_off_y;
  idx_t   r_col, r_row;
  size_t  r_size;
  dim_t   r_cols, r_rows;
  logic   r_flag, r_origin_miss;
  logic   r_busy, r_hit_valid, r_miss_valid, r_hit_flag;
  idx_t   r_hit_col, r_hit_row;

  logic   w_click, w_x_ge, w_y_ge, w_col_last, w_row_last;
  coord_t w_size_ext;

  assign w_click    = click_left | click_right;
  assign w_size_ext = {{(COORD_W-SIZE_W){1'b0}}, r_size};
  assign w_x_ge     = r_off_x >= w_size_ext;
  assign w_y_ge     = r_off_y >= w_size_ext;
  assign w_col_last = {1'b0, r_col} == (r_cols - dim_t'(1));
  assign w_row_last = {1'b0, r_row} == (r_rows - dim_t'(1));

  // NOTE: sequential state uses non-blocking (<=) so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: default assigned first so no branch leaves w_state_next unassigned, which would infer a latch.
    w_state_next = r_state;
    unique case (r_state)
      IDLE:  if (w_click) w_state_next = DIV_X;
      DIV_X: begin
        if (r_origin_miss)   w_state_next = MISS;
        else if (w_x_ge)     w_state_next = w_col_last ? MISS : DIV_X;
        else                 w_state_next = DIV_Y;
      end
      DIV_Y: begin
        if (w_y_ge)          w_state_next = w_row_last ? MISS : DIV_Y;
        else                 w_state_next = DONE;
      end
      DONE, MISS:            w_state_next = IDLE;
      default:               w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_off_x       <= '0;
      r_off_y       <= '0;
      r_col         <= '0;
      r_row         <= '0;
      r_size        <= '0;
      r_cols        <= '0;
      r_rows        <= '0;
      r_flag        <= 1'b0;
      r_origin_miss <= 1'b0;
      r_busy        <= 1'b0;
      r_hit_valid   <= 1'b0;
      r_miss_valid  <= 1'b0;
      r_hit_col     <= '0;
      r_hit_row     <= '0;
      r_hit_flag    <= 1'b0;
    end else begin
      r_busy       <= (w_state_next == DIV_X) || (w_state_next == DIV_Y);
      r_hit_valid  <= (w_state_next == DONE);
      r_miss_valid <= (w_state_next == MISS);

      unique case (r_state)
        IDLE: if (w_click) begin
          // x is offset by one: the renderer draws column 0 starting at board_xpos+1.
          r_off_x       <= mouse_xpos - board_xpos - coord_t'(1);
          r_off_y       <= mouse_ypos - board_ypos;
          r_col         <= '0;
          r_row         <= '0;
          r_size        <= button_size;
          r_cols        <= board_cols;
          r_rows        <= board_rows;
          r_flag        <= click_right;
          r_origin_miss <= origin_miss(mouse_xpos, mouse_ypos, board_xpos, board_ypos,
                                       button_size, board_cols, board_rows);
        end
        DIV_X: if (!r_origin_miss && w_x_ge && !w_col_last) begin
          r_off_x <= r_off_x - w_size_ext;
          r_col   <= r_col + idx_t'(1);
        end
        DIV_Y: if (w_y_ge && !w_row_last) begin
          r_off_y <= r_off_y - w_size_ext;
          r_row   <= r_row + idx_t'(1);
        end
        default: ;
      endcase

      if (w_state_next == DONE) begin
        r_hit_col  <= r_col;
        r_hit_row  <= r_row;
        r_hit_flag <= r_flag;
      end
    end
  end

  assign busy       = r_busy;
  assign hit_valid  = r_hit_valid;
  assign miss_valid = r_miss_valid;
  assign hit_col    = r_hit_col;
  assign hit_row    = r_hit_row;
  assign hit_flag   = r_hit_flag;

endmodule

// File: doc/board_hit_decode.md
BOARD_HIT_DECODE -- requirements
Module: board_hit_decode

Interface
REQ-001 SHALL have port clk, input, 1, system clock (65 MHz pixel clock domain).
REQ-002 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port mouse_xpos, input, 11, pointer x in screen pixels.
REQ-004 SHALL have port mouse_ypos, input, 11, pointer y in screen pixels.
REQ-005 SHALL have port click_left, input, 1, one-cycle pulse meaning reveal request.
REQ-006 SHALL have port click_right, input, 1, one-cycle pulse meaning flag request.
REQ-007 SHALL have port board_xpos, input, 11, board origin x, using the same value given to the button renderer.
REQ-008 SHALL have port board_ypos, input, 11, board origin y.
REQ-009 SHALL have port button_size, input, 7, button pitch in pixels.
REQ-010 SHALL have port board_cols, input, 5, column count, legal range 1..16.
REQ-011 SHALL have port board_rows, input, 5, row count, legal range 1..16.
REQ-012 SHALL have port busy, output, 1, high while a decode is in progress.
REQ-013 SHALL have port hit_valid, output, 1, one-cycle pulse meaning a button was hit.
REQ-014 SHALL have port miss_valid, output, 1, one-cycle pulse meaning the click fell outside the board.
REQ-015 SHALL have port hit_col, output, 4, column index, 0 = leftmost.
REQ-016 SHALL have port hit_row, output, 4, row index, 0 = top.
REQ-017 SHALL have port hit_flag, output, 1, set to 1 for a right click and 0 for a left click.

Function
REQ-018 SHALL use the FSM states IDLE, DIV_X, DIV_Y, DONE and MISS.
REQ-019 IDLE: on a rising edge with (click_left | click_right) the block SHALL capture all position and geometry inputs, load off_x = mouse_xpos - board_xpos - 1 and off_y = mouse_ypos - board_ypos (11-bit), clear col and row, latch hit_flag = click_right, set an origin-miss flag, and go to DIV_X.
REQ-020 The origin-miss flag SHALL be set when mouse_xpos <= board_xpos, mouse_ypos < board_ypos, button_size == 0, board_cols == 0 or board_rows == 0.
REQ-021 Simultaneous click_left and click_right SHALL be treated as a right click.
REQ-022 DIV_X behaviour SHALL be:
- origin-miss set: go to MISS.
- off_x >= button_size and col == board_cols-1: go to MISS.
- off_x >= button_size otherwise: subtract button_size from off_x, increment col, stay in DIV_X.
- off_x < button_size: go to DIV_Y.
REQ-023 DIV_Y SHALL behave the same as DIV_X, using off_y, row and board_rows; on off_y < button_size it SHALL go to DONE.
REQ-024 DONE and MISS SHALL each last exactly one cycle and then return to IDLE.
REQ-025 hit_valid SHALL be registered and high only in DONE; miss_valid SHALL be registered and high only in MISS.
REQ-026 hit_col, hit_row and hit_flag SHALL hold their last decoded values until the next DONE.
REQ-027 Latency for a hit SHALL be: hit_valid high in the cycle after rising edge number (col+row+2), counted from the click-sampling edge as edge 0.
REQ-028 Latency for an origin miss SHALL be 1 edge.
REQ-029 Latency for a column overflow SHALL be board_cols edges.
REQ-030 Latency for a row overflow SHALL be col+1+board_rows edges.
REQ-031 busy SHALL be high in DIV_X and DIV_Y.
REQ-032 Clicks arriving in any state other than IDLE SHALL be dropped, with no queueing.
REQ-033 Inputs SHALL be captured at the click edge only; later changes to geometry or position SHALL NOT affect the decode in progress.
REQ-034 Pixel x = board_xpos + 1 + k*button_size SHALL map to column k, and y = board_ypos + k*button_size SHALL map to row k; bevel and margin pixels count as part of the button.

Reset
REQ-035 rst SHALL force state IDLE and clear busy, hit_valid, miss_valid, hit_col, hit_row, hit_flag, off_x, off_y, col and row to 0 on the next edge.
REQ-036 rst asserted mid-decode SHALL abort the decode with no hit or miss pulse, and a click sampled in the same cycle as rst SHALL be ignored.

Structure
REQ-037 Constant MAX_BOARD_DIM = 16 and the index width (4) SHALL live in the shared board package, next to the button geometry constants.
REQ-038 The FSM enum SHALL be local to the module, with a single FSM and no sub-module.

Verification
REQ-039 Test 1 SHALL use board 100,100, size 40, 8x8, left click at (101,100); the bench SHALL require hit_valid at edge 2 with col 0, row 0, flag 0.
REQ-040 Test 2 SHALL use the same board with a right click at (221,260), i.e. off 120/160; the bench SHALL require hit at edge 9 with col 3, row 4, flag 1.
REQ-041 Test 3 SHALL use the same board with a click at (100,150); the bench SHALL require miss_valid at edge 1 and hit_col and hit_row unchanged.
REQ-042 Test 4 SHALL use the same board with a click at (421,100); the bench SHALL require miss_valid at edge 8 and no hit_valid.
REQ-043 Test 5 SHALL issue a second click 2 cycles after the test-2 click; the bench SHALL require it to be ignored, a single hit, and busy high for edges 1..8.
REQ-044 Test 6 SHALL assert rst at edge 4 of a decode; the bench SHALL require all outputs 0 and no pulse, and a click after reset SHALL decode normally.
